// File: rtl/vga_timing_pkg.sv
// Shared timing constants and coordinate type for the 640x480@60 raster path.
// Holds the default porch/sync/visible widths, the derived line/frame totals,
// the coordinate width and a small window-decode helper.
package vga_timing_pkg;

  localparam int unsigned COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FP      = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BP      = 48;
  localparam int unsigned H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FP      = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BP      = 33;
  localparam int unsigned V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

  // Half-open window test: lo <= val < hi.
  function automatic logic in_range(coord_t val, coord_t lo, coord_t hi);
    return (val >= lo) && (val < hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from the timing generator to the pixel stages.
//   DrawX/DrawY  scan coordinates
//   blank        1 = visible pixel
//   hs/vs        pipeline-delayed sync pulses
//   line_start   pulse at DrawX==0
//   frame_start  pulse at DrawX==0, DrawY==0
// master = generator side, slave = consumer side.
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  coord_t DrawX;
  coord_t DrawY;
  logic   blank;
  logic   hs;
  logic   vs;
  logic   line_start;
  logic   frame_start;

  modport master (
    output DrawX, DrawY, blank, hs, vs, line_start, frame_start
  );

  modport slave (
    input DrawX, DrawY, blank, hs, vs, line_start, frame_start
  );

endinterface

// File: rtl/sync_delay_line.sv
// Asynchronous-reset shift register used to line the sync pulses up with the
// downstream colour pipeline.
//   vga_clk  pixel clock
//   reset_n  asynchronous active-low reset; flushes every stage to RESET_VAL
//   d        input word
//   q        d delayed by DEPTH cycles (DEPTH=0 is a plain wire)
module sync_delay_line #(
  parameter int unsigned          DEPTH     = 2,
  parameter int unsigned          WIDTH     = 2,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic             vga_clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    assign q = d;
  end else begin : g_shift
    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          stage_q[i] <= RESET_VAL;
        end
      end else begin
        stage_q[0] <= d;
        for (int unsigned i = 1; i < DEPTH; i++) begin
          stage_q[i] <= stage_q[i-1];
        end
      end
    end

    assign q = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running raster timing generator (640x480@60 by default).
//   vga_clk  pixel clock
//   reset_n  asynchronous active-low reset
//   vid      timing bundle (master): DrawX, DrawY, blank, hs, vs,
//            line_start, frame_start
// Every output is registered. blank/line_start/frame_start and the raw syncs
// are decoded from the next-state counters so they describe the same pixel
// as the DrawX/DrawY they are registered alongside. Only hs/vs pass through
// the PIPE_DLY delay line.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE = vga_timing_pkg::H_VISIBLE,
  parameter int unsigned H_FP      = vga_timing_pkg::H_FP,
  parameter int unsigned H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int unsigned H_BP      = vga_timing_pkg::H_BP,
  parameter int unsigned V_VISIBLE = vga_timing_pkg::V_VISIBLE,
  parameter int unsigned V_FP      = vga_timing_pkg::V_FP,
  parameter int unsigned V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int unsigned V_BP      = vga_timing_pkg::V_BP,
  parameter bit          SYNC_POL  = 1'b0,
  parameter int unsigned PIPE_DLY  = 2
) (
  input  logic             vga_clk,
  input  logic             reset_n,
  vga_timing_gen_if.master vid
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 1024) begin : g_h_range
    $error("vga_timing_gen: H_TOTAL exceeds 1024");
  end
  if (V_TOTAL > 1024) begin : g_v_range
    $error("vga_timing_gen: V_TOTAL exceeds 1024");
  end
  if (PIPE_DLY > 7) begin : g_dly_range
    $error("vga_timing_gen: PIPE_DLY must be 0..7");
  end

  localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
  localparam coord_t H_VIS    = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS    = coord_t'(V_VISIBLE);
  localparam coord_t HS_START = coord_t'(H_VISIBLE + H_FP);
  localparam coord_t HS_END   = coord_t'(H_VISIBLE + H_FP + H_SYNC);
  localparam coord_t VS_START = coord_t'(V_VISIBLE + V_FP);
  localparam coord_t VS_END   = coord_t'(V_VISIBLE + V_FP + V_SYNC);

  localparam logic SYNC_OFF = ~SYNC_POL;

  // run_q holds the counters at 0,0 for the first edge after reset so that
  // pixel (0,0) is presented with its strobes before counting starts.
  logic   run_q;
  coord_t x_q, x_d;
  coord_t y_q, y_d;
  logic   blank_q, line_start_q, frame_start_q;
  logic   hs_raw_q, hs_raw_d;
  logic   vs_raw_q, vs_raw_d;
  logic [1:0] sync_dly;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (!run_q) begin
      x_d = '0;
      y_d = '0;
    end else if (x_q == H_LAST) begin
      x_d = '0;
      if (y_q == V_LAST) begin
        y_d = '0;
      end else begin
        y_d = y_q + coord_t'(1);
      end
    end else begin
      x_d = x_q + coord_t'(1);
    end

    hs_raw_d = in_range(x_d, HS_START, HS_END) ? SYNC_POL : SYNC_OFF;
    vs_raw_d = in_range(y_d, VS_START, VS_END) ? SYNC_POL : SYNC_OFF;
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q         <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      blank_q       <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      hs_raw_q      <= SYNC_OFF;
      vs_raw_q      <= SYNC_OFF;
    end else begin
      run_q         <= 1'b1;
      x_q           <= x_d;
      y_q           <= y_d;
      blank_q       <= (x_d < H_VIS) && (y_d < V_VIS);
      line_start_q  <= (x_d == '0);
      frame_start_q <= (x_d == '0) && (y_d == '0);
      hs_raw_q      <= hs_raw_d;
      vs_raw_q      <= vs_raw_d;
    end
  end

  sync_delay_line #(
    .DEPTH     (PIPE_DLY),
    .WIDTH     (2),
    .RESET_VAL ({2{SYNC_OFF}})
  ) u_sync_delay_line (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .d       ({hs_raw_q, vs_raw_q}),
    .q       (sync_dly)
  );

  assign vid.DrawX       = x_q;
  assign vid.DrawY       = y_q;
  assign vid.blank       = blank_q;
  assign vid.line_start  = line_start_q;
  assign vid.frame_start = frame_start_q;
  assign vid.hs          = sync_dly[1];
  assign vid.vs          = sync_dly[0];

endmodule
